// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter between the instruction-fill port and the data port.
// The data side wins ties. A starvation counter forces an instruction grant
// after STARVE_LIMIT back-to-back data completions while an instruction fill
// is pending. Each grant is followed by one IDLE cycle before the next.
module mem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err
);

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam int         CW        = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT  = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] starve_cnt;
  logic          i_done, d_done;

  // State register; reset aborts any access in flight.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state <= IDLE;
    else       state <= state_nxt;
  end

  // Count data completions that happened while a fill was waiting; any cycle
  // without a fill request, or the fill completing, clears it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST)                        starve_cnt <= '0;
    else if (!iREN || i_done)         starve_cnt <= '0;
    else if (d_done && starve_cnt != LIMIT) starve_cnt <= starve_cnt + CW'(1);
  end

  // Next-state and RAM/requester outputs. The granted side drives the RAM
  // live, so a dropped request pulls the strobes down in the same cycle.
  always_comb begin
    state_nxt = state;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;
    ram_err   = 1'b0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    case (state)
      IDLE: begin
        if (iREN && starve_cnt == LIMIT) state_nxt = IGRANT;
        else if (dREN || dWEN)           state_nxt = DGRANT;
        else if (iREN)                   state_nxt = IGRANT;
      end
      DGRANT: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (!(dREN || dWEN)) begin
          state_nxt = IDLE;
        end else if (ramstate == RS_ACCESS) begin
          dwait     = 1'b0;
          dload     = ramload;
          d_done    = 1'b1;
          state_nxt = IDLE;
        end else if (ramstate == RS_ERROR) begin
          ram_err = 1'b1;
        end
      end
      IGRANT: begin
        ramaddr = iaddr;
        if (!iREN) begin
          state_nxt = IDLE;
        end else begin
          ramREN = 1'b1;
          if (ramstate == RS_ACCESS) begin
            iwait     = 1'b0;
            iload     = ramload;
            i_done    = 1'b1;
            state_nxt = IDLE;
          end else if (ramstate == RS_ERROR) begin
            ram_err = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
